de_decode_stage: RTL

//  Decode stage. Sits directly downstream of the fetch stage and consumes its FE latch.

---
 rtl/de_decode_stage_pkg.sv | 87 ++++++++
 rtl/de_decode_stage_scoreboard.sv | 79 +++++++
 rtl/de_decode_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/de_decode_stage_pkg.sv
// ============================================================================
// Module  : de_decode_stage_pkg
// Brief   : Shared widths, RV32I opcodes, op-class encoding and latch layouts
//           for the decode stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package de_decode_stage_pkg;

    localparam int DBITS   = 32;
    localparam int REGNO   = 32;
    localparam int SB_BITS = 2;
    localparam int RBITS   = $clog2(REGNO);

    localparam logic [DBITS-1:0] c_BUS_CANARY_VALUE = 32'hC0DE_CAFE;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        OP_NONE    = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_OPIMM   = 4'd8,
        OP_OP      = 4'd9,
        OP_ILLEGAL = 4'd15
    } op_class_e;

    typedef struct packed {
        logic [31:0]      inst;
        logic [DBITS-1:0] pc;
        logic [DBITS-1:0] pcplus;
        logic [31:0]      inst_count;
        logic [31:0]      canary;
    } fe_latch_t;

    typedef struct packed {
        logic             valid;
        op_class_e        op;
        logic [31:0]      inst;
        logic [DBITS-1:0] pc;
        logic [DBITS-1:0] pcplus;
        logic [DBITS-1:0] rs1_val;
        logic [DBITS-1:0] rs2_val;
        logic [DBITS-1:0] imm;
        logic [RBITS-1:0] rd;
        logic             wr_rd;
        logic             illegal;
        logic [31:0]      inst_count;
        logic [31:0]      canary;
    } de_latch_t;

    localparam int FE_LATCH_WIDTH = $bits(fe_latch_t);
    localparam int DE_LATCH_WIDTH = $bits(de_latch_t);
    localparam int WB_WIDTH       = 1 + RBITS + DBITS;

    function automatic op_class_e classify(input logic [6:0] opcode);
        case (opcode)
            c_OPC_LUI:    return OP_LUI;
            c_OPC_AUIPC:  return OP_AUIPC;
            c_OPC_JAL:    return OP_JAL;
            c_OPC_JALR:   return OP_JALR;
            c_OPC_BRANCH: return OP_BRANCH;
            c_OPC_LOAD:   return OP_LOAD;
            c_OPC_STORE:  return OP_STORE;
            c_OPC_OPIMM:  return OP_OPIMM;
            c_OPC_OP:     return OP_OP;
            default:      return OP_ILLEGAL;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/de_decode_stage_scoreboard.sv
// ============================================================================
// Module  : de_scoreboard
// Brief   : Per-register in-flight writer counters with issue increment,
//           WB retire decrement and busy/full queries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module de_scoreboard #(
    parameter int REGNO   = 32,
    parameter int SB_BITS = 2,
    parameter int RBITS   = $clog2(REGNO)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_inc_en,
    input  logic [RBITS-1:0]   i_inc_reg,
    input  logic               i_dec_en,
    input  logic [RBITS-1:0]   i_dec_reg,
    input  logic [RBITS-1:0]   i_rs1,
    input  logic [RBITS-1:0]   i_rs2,
    input  logic [RBITS-1:0]   i_rd,
    output logic [SB_BITS-1:0] o_rs1_cnt,
    output logic [SB_BITS-1:0] o_rs2_cnt,
    output logic               o_rd_full
);

    localparam logic [SB_BITS-1:0] c_CNT_MAX = '1;

    logic [SB_BITS-1:0] r_cnt      [REGNO];
    logic [SB_BITS-1:0] w_cnt_next [REGNO];
    logic [REGNO-1:0]   w_inc_hit;
    logic [REGNO-1:0]   w_dec_hit;
    logic               w_dec_underflow;

    always_comb begin
        w_inc_hit       = i_inc_en ? (REGNO'(1) << i_inc_reg) : '0;
        w_dec_hit       = i_dec_en ? (REGNO'(1) << i_dec_reg) : '0;
        w_dec_underflow = 1'b0;
        for (int i = 0; i < REGNO; i++) begin
            w_cnt_next[i] = r_cnt[i];
            // x0 is never tracked; simultaneous inc/dec cancel out
            if (i != 0) begin
                if (w_inc_hit[i] && !w_dec_hit[i]) begin
                    w_cnt_next[i] = r_cnt[i] + SB_BITS'(1);
                end else if (w_dec_hit[i] && !w_inc_hit[i]) begin
                    if (r_cnt[i] == '0) begin
                        w_dec_underflow = 1'b1;
                    end else begin
                        w_cnt_next[i] = r_cnt[i] - SB_BITS'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGNO; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGNO; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign o_rs1_cnt = r_cnt[i_rs1];
    assign o_rs2_cnt = r_cnt[i_rs2];
    assign o_rd_full = (r_cnt[i_rd] == c_CNT_MAX);

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !w_dec_underflow);
`endif

endmodule

`default_nettype wire

// File: rtl/de_decode_stage.sv
// ============================================================================
// Module  : de_decode_stage
// Brief   : RV32I decode stage: decode, regfile read/write, RAW scoreboard,
//           fetch stall, branch squash and registered DE latch.
//           Optional macro DE_WB_BYPASS_EN forwards same-cycle WB writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module de_decode_stage
    import de_decode_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FE_LATCH_WIDTH-1:0] from_FE_latch,
    input  logic                      from_AGEX_to_DE,
    input  logic [WB_WIDTH-1:0]       from_WB_to_DE,
    output logic                      from_DE_to_FE,
    output logic [DE_LATCH_WIDTH-1:0] DE_latch_out,
    output logic                      canary_err
);

    fe_latch_t          w_fe;
    logic               w_wb_en;
    logic [RBITS-1:0]   w_wb_reg;
    logic [DBITS-1:0]   w_wb_data;
    logic               w_wb_wr;

    logic               w_valid;
    logic [RBITS-1:0]   w_rs1;
    logic [RBITS-1:0]   w_rs2;
    logic [RBITS-1:0]   w_rd;
    op_class_e          w_op;
    logic [DBITS-1:0]   w_imm;
    logic               w_use_rs1;
    logic               w_use_rs2;
    logic               w_writes;
    logic               w_wr_rd;
    logic               w_illegal;

    logic [DBITS-1:0]   w_rs1_val;
    logic [DBITS-1:0]   w_rs2_val;
    logic               w_rs1_fwd;
    logic               w_rs2_fwd;
    logic [SB_BITS-1:0] w_rs1_cnt;
    logic [SB_BITS-1:0] w_rs2_cnt;
    logic               w_rs1_busy;
    logic               w_rs2_busy;
    logic               w_rd_full;
    logic               w_hazard;
    logic               w_issue;

    de_latch_t          w_de_next;
    de_latch_t          r_de;
    logic [DBITS-1:0]   r_regs [REGNO];
    logic               r_canary_err;

    assign w_fe                            = fe_latch_t'(from_FE_latch);
    assign {w_wb_en, w_wb_reg, w_wb_data}  = from_WB_to_DE;
    assign w_wb_wr                         = w_wb_en && (w_wb_reg != '0);

    assign w_valid = (w_fe.inst != '0);
    assign w_rs1   = w_fe.inst[19:15];
    assign w_rs2   = w_fe.inst[24:20];
    assign w_rd    = w_fe.inst[11:7];

    always_comb begin
        w_op      = classify(w_fe.inst[6:0]);
        w_imm     = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            OP_LUI, OP_AUIPC: begin
                w_imm    = {w_fe.inst[31:12], 12'b0};
                w_writes = 1'b1;
            end
            OP_JAL: begin
                w_imm    = {{11{w_fe.inst[31]}}, w_fe.inst[31], w_fe.inst[19:12],
                            w_fe.inst[20], w_fe.inst[30:21], 1'b0};
                w_writes = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                w_imm     = {{20{w_fe.inst[31]}}, w_fe.inst[31:20]};
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            OP_BRANCH: begin
                w_imm     = {{19{w_fe.inst[31]}}, w_fe.inst[31], w_fe.inst[7],
                             w_fe.inst[30:25], w_fe.inst[11:8], 1'b0};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_STORE: begin
                w_imm     = {{20{w_fe.inst[31]}}, w_fe.inst[31:25], w_fe.inst[11:7]};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_wr_rd = w_writes && (w_rd != '0);

    // Register read; x0 is never written so it always reads zero
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        w_rs2_val = r_regs[w_rs2];
        w_rs1_fwd = 1'b0;
        w_rs2_fwd = 1'b0;
`ifdef DE_WB_BYPASS_EN
        w_rs1_fwd = w_wb_wr && (w_wb_reg == w_rs1);
        w_rs2_fwd = w_wb_wr && (w_wb_reg == w_rs2);
        if (w_rs1_fwd) w_rs1_val = w_wb_data;
        if (w_rs2_fwd) w_rs2_val = w_wb_data;
`endif
    end

    de_scoreboard #(
        .REGNO   (REGNO),
        .SB_BITS (SB_BITS),
        .RBITS   (RBITS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .i_inc_en  (w_issue && w_wr_rd),
        .i_inc_reg (w_rd),
        .i_dec_en  (w_wb_wr),
        .i_dec_reg (w_wb_reg),
        .i_rs1     (w_rs1),
        .i_rs2     (w_rs2),
        .i_rd      (w_rd),
        .o_rs1_cnt (w_rs1_cnt),
        .o_rs2_cnt (w_rs2_cnt),
        .o_rd_full (w_rd_full)
    );

    // A forwarded source sees its counter one lower: the retiring writer is done
    assign w_rs1_busy = ((w_rs1_cnt - SB_BITS'(w_rs1_fwd)) != '0);
    assign w_rs2_busy = ((w_rs2_cnt - SB_BITS'(w_rs2_fwd)) != '0);

    assign w_hazard = w_valid && ((w_use_rs1 && w_rs1_busy) ||
                                  (w_use_rs2 && w_rs2_busy) ||
                                  (w_wr_rd && w_rd_full));
    assign w_issue  = w_valid && !w_hazard && !from_AGEX_to_DE;

    assign from_DE_to_FE = w_hazard && !from_AGEX_to_DE;

    always_comb begin
        w_de_next = '0;
        if (w_issue) begin
            w_de_next.valid      = 1'b1;
            w_de_next.op         = w_op;
            w_de_next.inst       = w_fe.inst;
            w_de_next.pc         = w_fe.pc;
            w_de_next.pcplus     = w_fe.pcplus;
            w_de_next.rs1_val    = w_rs1_val;
            w_de_next.rs2_val    = w_rs2_val;
            w_de_next.imm        = w_imm;
            w_de_next.rd         = w_rd;
            w_de_next.wr_rd      = w_wr_rd;
            w_de_next.illegal    = w_illegal;
            w_de_next.inst_count = w_fe.inst_count;
            w_de_next.canary     = w_fe.canary;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_de         <= '0;
            r_canary_err <= 1'b0;
            for (int i = 0; i < REGNO; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_de <= w_de_next;
            if (w_valid && (w_fe.canary != c_BUS_CANARY_VALUE)) begin
                r_canary_err <= 1'b1;
            end
            if (w_wb_wr) begin
                r_regs[w_wb_reg] <= w_wb_data;
            end
        end
    end

    assign DE_latch_out = r_de;
    assign canary_err   = r_canary_err;

endmodule

`default_nettype wire
